axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter ID_W, default 4, AXI ID width.
REQ-002 Parameter ID_VAL, default 0, constant driven on ARID/AWID.
REQ-003 Parameter ADDR_W, default 32, address width.
REQ-004 Parameter DATA_W, default 32, beat width; legal values 32 or 64.
REQ-005 Parameter BEATS, default 1, beats per transfer; legal values 1, 2, 4, 8.
REQ-006 The ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_read  in  1  line read request, level.
- req_write  in  1  line write request, level.
- addr  in  ADDR_W  request address.
- wdata  in  BEATS*DATA_W  write line, beat 0 in LSBs.
- wstrb  in  BEATS*DATA_W/8  byte strobes, beat-aligned like wdata.
- rdata  out  BEATS*DATA_W  read line, beat 0 in LSBs.
- stall  out  1  request pending and not complete.
- err  out  1  completed transfer returned non-OKAY response.
- AW channel: AWID, AWADDR, AWLEN(8), AWSIZE(3), AWBURST(2), AWVALID out; AWREADY in.
- W channel: WDATA, WSTRB, WLAST, WVALID out; WREADY in.
- B channel: BID, BRESP in; BVALID in; BREADY out.
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID out; ARREADY in.
- R channel: RID, RDATA, RRESP, RLAST, RVALID in; RREADY out.

Function
REQ-007 States SHALL be IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE.
REQ-008 IDLE: req_read -> RADDR; else req_write -> WADDR; read wins when both are asserted.
REQ-009 On leaving IDLE, addr, wdata and wstrb SHALL be latched; addr low log2(BEATS*DATA_W/8) bits forced to zero.
REQ-010 ARLEN/AWLEN SHALL be BEATS-1, AR/AWSIZE log2(DATA_W/8), AR/AWBURST 2'b01 (INCR), IDs ID_VAL.
REQ-011 ARVALID/AWVALID SHALL be high only in RADDR/WADDR, stable until READY; the handshake moves to RDATA/WDATA.
REQ-012 RREADY SHALL be high only in RDATA; each R handshake stores RDATA into rdata slice[beat], beat counter +1.
REQ-013 R handshake with RLAST=1 SHALL go to DONE regardless of beat count; the counter wraps to 0.
REQ-014 WDATA state: WVALID high, WDATA/WSTRB = latched slice[beat], WLAST=1 when beat==BEATS-1; each handshake increments beat; last beat -> WRESP.
REQ-015 WRESP: BREADY high; BVALID handshake -> DONE.
REQ-016 err SHALL be set in DONE if any RRESP or BRESP of the transfer was nonzero; cleared on leaving IDLE.
REQ-017 stall = (state==IDLE & (req_read|req_write)) | (state not in {IDLE, DONE}).
REQ-018 DONE SHALL last exactly one cycle with stall=0, rdata stable, requests ignored; then IDLE.
REQ-019 rdata SHALL hold its value until overwritten by a later read beat.
REQ-020 RID/BID SHALL be ignored; request input changes after latching SHALL NOT affect the transfer.
REQ-021 Minimum read latency: request at cycle 0, ARREADY=1, RVALID=1 -> stall low at cycle BEATS+2.

Reset
REQ-022 rst low SHALL asynchronously force IDLE, beat=0, rdata=0, err=0, all VALID/READY outputs 0, WLAST=0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no further handshakes; operation resumes from IDLE after rst rises.

Structure
REQ-024 Shared package axi_pkg SHALL hold the state enum, burst codes (FIXED/INCR/WRAP) and resp codes (OKAY/EXOKAY/SLVERR/DECERR).
REQ-025 No sub-module SHALL be used; a single module with one state register and one beat counter.

Verification
REQ-026 BEATS=1: req_read, addr 0x1004, ARREADY=1, RDATA 0xDEADBEEF RLAST=1 -> ARADDR 0x1004, ARLEN 0, rdata 0xDEADBEEF, stall low at cycle 3.
REQ-027 BEATS=4: req_write, addr 0x2008, wdata beats 1..4 -> AWADDR 0x2000, AWLEN 3, four W beats 1,2,3,4, WLAST only on 4th, DONE after BVALID.
REQ-028 Both requests together -> read issued first; write issued after DONE only if still requested.
REQ-029 BEATS=4 read with RVALID toggling and RRESP=2 on beat 2 -> beats stored in order, err=1 in DONE, err=0 on next transfer start.
REQ-030 Assert rst low during WDATA beat 2 -> all VALIDs 0 immediately, state IDLE, no WLAST emitted.
REQ-031 ARREADY held low 10 cycles -> ARVALID and ARADDR stable throughout, stall high.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared FSM state encoding and AXI burst/response codes
package axi_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WDATA,
    ST_WRESP,
    ST_DONE
  } state_t;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-line AXI INCR burst read/write master
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ID_VAL = 0,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_read,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [BEATS*DATA_W-1:0]    wdata,
  input  logic [BEATS*DATA_W/8-1:0]  wstrb,
  output logic [BEATS*DATA_W-1:0]    rdata,
  output logic                       stall,
  output logic                       err,
  output logic [ID_W-1:0]            AWID,
  output logic [ADDR_W-1:0]          AWADDR,
  output logic [7:0]                 AWLEN,
  output logic [2:0]                 AWSIZE,
  output logic [1:0]                 AWBURST,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [DATA_W-1:0]          WDATA,
  output logic [DATA_W/8-1:0]        WSTRB,
  output logic                       WLAST,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic [ID_W-1:0]            BID,
  input  logic [1:0]                 BRESP,
  input  logic                       BVALID,
  output logic                       BREADY,
  output logic [ID_W-1:0]            ARID,
  output logic [ADDR_W-1:0]          ARADDR,
  output logic [7:0]                 ARLEN,
  output logic [2:0]                 ARSIZE,
  output logic [1:0]                 ARBURST,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [ID_W-1:0]            RID,
  input  logic [DATA_W-1:0]          RDATA,
  input  logic [1:0]                 RRESP,
  input  logic                       RLAST,
  input  logic                       RVALID,
  output logic                       RREADY
);
  localparam int BYTES = DATA_W / 8;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  state_t state, nxt;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] addr_q;
  logic [BEATS*DATA_W-1:0] wdata_q;
  logic [BEATS*BYTES-1:0] wstrb_q;
  logic err_acc, start, r_hs, w_hs, b_hs, resp_bad;
  logic unused_ids;
  assign unused_ids = ^{RID, BID};
  assign ARVALID = state == ST_RADDR;
  assign RREADY  = state == ST_RDATA;
  assign AWVALID = state == ST_WADDR;
  assign WVALID  = state == ST_WDATA;
  assign BREADY  = state == ST_WRESP;
  assign WLAST   = WVALID && beat == LAST;
  assign stall   = (state == ST_IDLE && (req_read || req_write)) || (state != ST_IDLE && state != ST_DONE);
  assign ARID    = ID_W'(ID_VAL);
  assign AWID    = ID_W'(ID_VAL);
  assign ARADDR  = addr_q;
  assign AWADDR  = addr_q;
  assign ARLEN   = 8'(BEATS - 1);
  assign AWLEN   = 8'(BEATS - 1);
  assign ARSIZE  = 3'($clog2(BYTES));
  assign AWSIZE  = 3'($clog2(BYTES));
  assign ARBURST = BURST_INCR;
  assign AWBURST = BURST_INCR;
  assign WDATA   = wdata_q[beat*DATA_W +: DATA_W];
  assign WSTRB   = wstrb_q[beat*BYTES +: BYTES];
  assign r_hs    = RREADY && RVALID;
  assign w_hs    = WVALID && WREADY;
  assign b_hs    = BREADY && BVALID;
  assign start   = state == ST_IDLE && nxt != ST_IDLE;
  assign resp_bad = (r_hs && RRESP != RESP_OKAY) || (b_hs && BRESP != RESP_OKAY);
  // next-state selection; a read request beats a simultaneous write
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  nxt = req_read ? ST_RADDR : req_write ? ST_WADDR : ST_IDLE;
      ST_RADDR: nxt = ARREADY ? ST_RDATA : ST_RADDR;
      ST_RDATA: nxt = (RVALID && RLAST) ? ST_DONE : ST_RDATA;
      ST_WADDR: nxt = AWREADY ? ST_WDATA : ST_WADDR;
      ST_WDATA: nxt = (WREADY && beat == LAST) ? ST_WRESP : ST_WDATA;
      ST_WRESP: nxt = BVALID ? ST_DONE : ST_WRESP;
      default:  nxt = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else state <= nxt;
  end
  // request latch, beat counter, read line assembly and error tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata   <= '0;
      err_acc <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= addr & ~ADDR_W'(BEATS * BYTES - 1);
        wdata_q <= wdata;
        wstrb_q <= wstrb;
        err_acc <= 1'b0;
        err     <= 1'b0;
      end else begin
        err_acc <= err_acc | resp_bad;
        if (nxt == ST_DONE) err <= err_acc | resp_bad;
      end
      if (r_hs) rdata[beat*DATA_W +: DATA_W] <= RDATA;
      if (r_hs || w_hs) beat <= ((r_hs && RLAST) || beat == LAST) ? '0 : beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: randomized slave with transaction-level reference checks
module tb_axi_burst_master;
  localparam int BEATS = 4;
  localparam int DW = 32;
  localparam int LW = BEATS * DW;
  localparam int SW = LW / 8;
  localparam int IDV = 5;
  logic clk = 1'b0;
  logic rst;
  logic req_read, req_write;
  logic [31:0] addr;
  logic [LW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic stall, err;
  logic [3:0] AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] exp_addr;
  logic [LW-1:0] exp_line, last_rd;
  logic [SW-1:0] exp_strb;

  axi_burst_master #(.ID_W(4), .ID_VAL(IDV), .ADDR_W(32), .DATA_W(DW), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .stall(stall), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY), .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
    .BREADY(BREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [1:0] rsp(input int pct);
    return roll(pct) ? 2'($urandom_range(3, 1)) : 2'b00;
  endfunction

  task automatic slave_quiet();
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0; RLAST = 0;
    RRESP = 0; BRESP = 0; RDATA = $urandom; RID = 4'($urandom); BID = 4'($urandom);
  endtask

  task automatic pick();
    addr = $urandom;
    exp_addr = addr & ~32'hF;
    exp_line = {$urandom, $urandom, $urandom, $urandom};
    exp_strb = 16'($urandom);
    wdata = exp_line;
    wstrb = exp_strb;
  endtask

  // raise the request, let it be latched, then scramble inputs the transfer must ignore
  task automatic launch(input bit rd, input bit wr);
    req_read = rd;
    req_write = wr;
    #1 check("req_stall", stall, 1);
    @(negedge clk);
    check("start_err_clear", err, 0);
    check("start_stall", stall, 1);
    req_read = 0;
    req_write = rd & wr;
    addr = $urandom;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    wstrb = 16'($urandom);
  endtask

  // play the slave until the transfer completes, checking every channel against the line
  task automatic run(input bit rd, input int pct, input int err_pct, output int cycles);
    int beat = 0;
    bit fin = 0;
    bit last = 0;
    bit exp_err = 0;
    cycles = 0;
    while (!fin && cycles < 400) begin
      if (last) begin
        check("done_stall", stall, 0);
        check("done_err", err, exp_err);
        check("done_rdata", rdata, rd ? exp_line : last_rd);
        check("done_valids", {ARVALID, AWVALID, WVALID, RREADY, BREADY}, 0);
        if (rd) last_rd = exp_line;
        slave_quiet();
        fin = 1;
      end else begin
        check("busy_stall", stall, 1);
        check("channel", rd ? {AWVALID, WVALID, BREADY} : {ARVALID, RREADY, 1'b0}, 0);
        slave_quiet();
        if (ARVALID) begin
          check("ARADDR", ARADDR, exp_addr);
          check("ARLEN", ARLEN, BEATS - 1);
          check("ARSIZE", ARSIZE, 2);
          check("ARBURST", ARBURST, 1);
          check("ARID", ARID, IDV);
          ARREADY = roll(pct);
        end
        if (RREADY) begin
          RVALID = roll(pct);
          RDATA = exp_line[beat*DW +: DW];
          RLAST = beat == BEATS - 1;
          RRESP = rsp(err_pct);
          if (RVALID) begin
            exp_err |= RRESP != 0;
            last = RLAST;
            beat++;
          end
        end
        if (AWVALID) begin
          check("AWADDR", AWADDR, exp_addr);
          check("AWLEN", AWLEN, BEATS - 1);
          check("AWSIZE", AWSIZE, 2);
          check("AWBURST", AWBURST, 1);
          check("AWID", AWID, IDV);
          AWREADY = roll(pct);
        end
        if (WVALID) begin
          check("WDATA", WDATA, exp_line[beat*DW +: DW]);
          check("WSTRB", WSTRB, exp_strb[beat*4 +: 4]);
          check("WLAST", WLAST, beat == BEATS - 1);
          WREADY = roll(pct);
          if (WREADY) beat++;
        end
        if (BREADY) begin
          check("w_beats", beat, BEATS);
          BVALID = roll(pct);
          BRESP = rsp(err_pct);
          if (BVALID) begin
            exp_err |= BRESP != 0;
            last = 1;
          end
        end
      end
      if (!fin) begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!fin) check("timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_rdata_hold", rdata, last_rd);
  endtask

  initial begin
    rst = 0;
    req_read = 0;
    req_write = 0;
    addr = 0;
    wdata = 0;
    wstrb = 0;
    last_rd = 0;
    slave_quiet();
    repeat (2) @(negedge clk);
    check("rst_outs", {stall, err, ARVALID, AWVALID, WVALID, RREADY, BREADY, WLAST}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1;
    @(negedge clk);
    pick();
    launch(1, 0);
    run(1, 100, 0, cyc);
    check("read_latency", cyc + 1, BEATS + 2);
    idle();
    pick();
    launch(1, 0);
    for (int i = 0; i < 10; i++) begin
      ARREADY = 0;
      check("ar_hold_valid", ARVALID, 1);
      check("ar_hold_addr", ARADDR, exp_addr);
      check("ar_hold_stall", stall, 1);
      @(negedge clk);
    end
    run(1, 70, 0, cyc);
    idle();
    pick();
    launch(1, 1);
    run(1, 60, 30, cyc);
    @(negedge clk);
    check("both_write_pending", stall, 1);
    check("both_no_aw_in_idle", AWVALID, 0);
    pick();
    launch(0, 1);
    run(0, 60, 30, cyc);
    idle();
    for (int t = 0; t < 30; t++) begin
      automatic bit rd = 1'($urandom_range(1));
      pick();
      launch(rd, !rd);
      run(rd, int'($urandom_range(100, 30)), 25, cyc);
      idle();
    end
    pick();
    launch(0, 1);
    AWREADY = 1;
    @(negedge clk);
    AWREADY = 0;
    WREADY = 1;
    repeat (2) @(negedge clk);
    check("pre_rst_wvalid", WVALID, 1);
    check("pre_rst_wlast", WLAST, 0);
    #2 rst = 0;
    #1;
    check("mid_rst_outs", {stall, err, ARVALID, AWVALID, WVALID, RREADY, BREADY, WLAST}, 0);
    check("mid_rst_rdata", rdata, 0);
    slave_quiet();
    @(negedge clk);
    check("rst_hold_wlast", WLAST, 0);
    rst = 1;
    last_rd = 0;
    idle();
    pick();
    launch(1, 0);
    run(1, 80, 20, cyc);
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
